// File: rtl/mux_scan_sequencer.sv
// Select-line sequencer for a 4:1 mux: dwells on each enabled input, then emits a tagged sample.
// Optional SCAN_CNT_EN adds an 8-bit completed-pass counter output scan_cnt.
module mux_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode_cont,
    input  logic [3:0] ch_mask,
    input  logic       y_in,
    output logic       sa,
    output logic       sb,
    output logic       busy,
    output logic       sample_valid,
    output logic [1:0] sample_ch,
    output logic       sample_data,
    output logic       done
`ifdef SCAN_CNT_EN
    ,
    output logic [7:0] scan_cnt
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       mask_q, mask_d;
    logic             mode_q, mode_d;
    logic             valid_q, valid_d;
    logic [1:0]       ch_q, ch_d;
    logic             data_q, data_d;
    logic             done_q, done_d;
    logic             pass_end;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = i[1:0];
        return r;
    endfunction

    function automatic logic [1:0] highest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (m[i]) r = i[1:0];
        return r;
    endfunction

    // Nearest enabled channel above s, wrapping; s itself if it is the only one.
    function automatic logic [1:0] next_ch(input logic [1:0] s, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] c;
        r = s;
        for (int k = 3; k >= 1; k--) begin
            c = s + 2'(k);
            if (m[c]) r = c;
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        mask_d   = mask_q;
        mode_d   = mode_q;
        valid_d  = 1'b0;
        ch_d     = ch_q;
        data_d   = data_q;
        done_d   = 1'b0;
        pass_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop && ch_mask != 4'd0) begin
                    state_d = SCAN;
                    mask_d  = ch_mask;
                    mode_d  = mode_cont;
                    sel_d   = lowest(ch_mask);
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    valid_d  = 1'b1;
                    ch_d     = sel_q;
                    data_d   = y_in;
                    cnt_d    = '0;
                    pass_end = (sel_q == highest(mask_q));
                    if (pass_end && !mode_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sel_d = next_ch(sel_q, mask_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            mask_q  <= 4'd0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            ch_q    <= 2'd0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

`ifdef SCAN_CNT_EN
    logic [7:0] pass_q;

    always_ff @(posedge clk) begin
        if (rst)
            pass_q <= 8'd0;
        else if (pass_end)
            pass_q <= pass_q + 8'd1;
    end

    assign scan_cnt = pass_q;
`endif

    assign sa           = sel_q[0];
    assign sb           = sel_q[1];
    assign busy         = (state_q == SCAN);
    assign sample_valid = valid_q;
    assign sample_ch    = ch_q;
    assign sample_data  = data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: scenario table, corner sequences and random traffic
// against a channel-list reference model, on a DWELL=4 and a DWELL=1 instance.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode_cont, y_in;
    logic [3:0] ch_mask;

    logic       sa0, sb0, busy0, sv0, sd0, dn0;
    logic [1:0] sch0;
    logic       sa1, sb1, busy1, sv1, sd1, dn1;
    logic [1:0] sch1;
    logic [7:0] sc0, sc1;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux_scan_sequencer #(.DWELL(4), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .mode_cont(mode_cont), .ch_mask(ch_mask), .y_in(y_in),
        .sa(sa0), .sb(sb0), .busy(busy0), .sample_valid(sv0),
        .sample_ch(sch0), .sample_data(sd0), .done(dn0)
`ifdef SCAN_CNT_EN
        , .scan_cnt(sc0)
`endif
    );

    mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .mode_cont(mode_cont), .ch_mask(ch_mask), .y_in(y_in),
        .sa(sa1), .sb(sb1), .busy(busy1), .sample_valid(sv1),
        .sample_ch(sch1), .sample_data(sd1), .done(dn1)
`ifdef SCAN_CNT_EN
        , .scan_cnt(sc1)
`endif
    );

`ifndef SCAN_CNT_EN
    assign sc0 = 8'd0;
    assign sc1 = 8'd0;
`endif

    // Reference: ordered list of enabled channels walked by index.
    typedef struct {
        bit            act;
        bit [3:0][1:0] chl;
        int            nch;
        int            idx;
        int            age;
        bit            cont;
        bit [1:0]      sel;
        bit            sv;
        bit [1:0]      sch;
        bit            sd;
        bit            dn;
        int            passes;
    } model_t;

    model_t m0, m1;

    function automatic model_t step(model_t m, int dwell, logic r, logic st,
                                    logic sp, logic md, logic [3:0] mk, logic y);
        model_t n;
        model_t z;
        n = m;
        n.sv = 1'b0;
        n.dn = 1'b0;
        if (r) return z;
        if (!m.act) begin
            if (st && !sp && mk != 4'd0) begin
                n.nch = 0;
                for (int c = 0; c < 4; c++)
                    if (mk[c]) begin
                        n.chl[n.nch] = 2'(c);
                        n.nch++;
                    end
                n.idx = 0;
                n.age = 0;
                n.act = 1'b1;
                n.cont = md;
                n.sel = n.chl[0];
            end
        end else if (sp) begin
            n.act = 1'b0;
            n.age = 0;
        end else if (m.age == dwell - 1) begin
            n.sv = 1'b1;
            n.sch = m.sel;
            n.sd = y;
            n.age = 0;
            if (m.idx == m.nch - 1) begin
                n.passes = m.passes + 1;
                if (!m.cont) begin
                    n.dn = 1'b1;
                    n.act = 1'b0;
                end else begin
                    n.idx = 0;
                    n.sel = m.chl[0];
                end
            end else begin
                n.idx = m.idx + 1;
                n.sel = m.chl[m.idx + 1];
            end
        end else begin
            n.age = m.age + 1;
        end
        return n;
    endfunction

    function automatic logic [15:0] exp_of(model_t m);
        logic [7:0] pc;
`ifdef SCAN_CNT_EN
        pc = 8'(m.passes);
`else
        pc = 8'd0;
`endif
        return {m.sel[1], m.sel[0], m.act, m.sv, m.sch, m.sd, m.dn, pc};
    endfunction

    wire [15:0] g0 = {sb0, sa0, busy0, sv0, sch0, sd0, dn0, sc0};
    wire [15:0] g1 = {sb1, sa1, busy1, sv1, sch1, sd1, dn1, sc1};

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmpi(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m0 = step(m0, 4, rst, start, stop, mode_cont, ch_mask, y_in);
        m1 = step(m1, 1, rst, start, stop, mode_cont, ch_mask, y_in);
    end

    always @(negedge clk)
        if (chk_en) begin
            cmp("model_dwell4", g0, exp_of(m0));
            cmp("model_dwell1", g1, exp_of(m1));
        end

    typedef struct {
        logic [3:0] mask;
        logic       mode;
        logic       with_stop;
        int         stop_at;
        int         restart_at;
        int         n;
        int         exp_samples;
        int         exp_done;
        logic [1:0] exp_sel;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[7];

    task automatic run_vec(input vec_t v, input int id);
        int ns;
        int nd;
        @(negedge clk); #1;
        stop = 1'b1;
        start = 1'b0;
        @(negedge clk); #1;
        stop = v.with_stop;
        start = 1'b1;
        ch_mask = v.mask;
        mode_cont = v.mode;
        ns = 0;
        nd = 0;
        for (int i = 1; i <= v.n; i++) begin
            @(negedge clk); #1;
            ns += int'(sv0);
            nd += int'(dn0);
            start = (i == v.restart_at);
            ch_mask = (i == v.restart_at) ? 4'hF : v.mask;
            mode_cont = (i == v.restart_at) ? 1'b1 : v.mode;
            stop = (i == v.stop_at);
            y_in = 1'($urandom);
        end
        cmpi($sformatf("tbl%0d_samples", id), ns, v.exp_samples);
        cmpi($sformatf("tbl%0d_done", id), nd, v.exp_done);
        cmpi($sformatf("tbl%0d_sel", id), int'({sb0, sa0}), int'(v.exp_sel));
        cmpi($sformatf("tbl%0d_busy", id), int'(busy0), int'(v.exp_busy));
    endtask

    initial begin
        tbl[0] = '{4'hF, 1'b0, 1'b0, 0, 0, 20, 4, 1, 2'd3, 1'b0};
        tbl[1] = '{4'hA, 1'b1, 1'b0, 0, 0, 20, 4, 0, 2'd1, 1'b1};
        tbl[2] = '{4'hF, 1'b0, 1'b0, 10, 0, 16, 2, 0, 2'd2, 1'b0};
        tbl[3] = '{4'h0, 1'b0, 1'b0, 0, 0, 8, 0, 0, 2'd2, 1'b0};
        tbl[4] = '{4'h8, 1'b0, 1'b0, 0, 0, 10, 1, 1, 2'd3, 1'b0};
        tbl[5] = '{4'hF, 1'b0, 1'b1, 0, 0, 8, 0, 0, 2'd3, 1'b0};
        tbl[6] = '{4'h6, 1'b0, 1'b0, 0, 3, 12, 2, 1, 2'd2, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        mode_cont = 1'b0;
        ch_mask = 4'd0;
        y_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #1;
        cmp("reset_dwell4", g0, 16'h0000);
        rst = 1'b0;

        for (int t = 0; t < 7; t++)
            run_vec(tbl[t], t);

        // Single channel with one-cycle dwell: a sample every cycle, then reset mid-scan.
        @(negedge clk); #1;
        stop = 1'b1;
        @(negedge clk); #1;
        stop = 1'b0;
        start = 1'b1;
        ch_mask = 4'b0100;
        mode_cont = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            cmpi("d1_every_cycle", int'(sv1), 1);
            cmpi("d1_channel", int'(sch1), 2);
            cmpi("d1_sel", int'({sb1, sa1}), 2);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        cmp("rst_mid_dwell1", g1, 16'h0000);
        cmp("rst_mid_dwell4", g0, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 19) == 0);
            ch_mask = 4'($urandom);
            mode_cont = 1'($urandom);
            y_in = 1'($urandom);
        end

        // Long continuous run on two channels so the pass counter wraps.
        @(negedge clk); #1;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        start = 1'b1;
        ch_mask = 4'b0011;
        mode_cont = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            ch_mask = 4'($urandom);
            mode_cont = 1'($urandom);
            y_in = 1'($urandom);
        end
        stop = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        cmpi("final_idle", int'(busy0 | busy1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
